// File: rtl/uart_core.sv
// Full-duplex UART engine: shared oversampling tick, mid-bit sampling receiver and start/busy transmitter.
// Define UART_PARITY_EN to insert/check a parity bit after the data bits.
`timescale 1ns/1ps
module uart_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_50mhz,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic                 tx_out,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int DIV_RAW    = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int STOP_TICKS = STOP_BITS * OVERSAMPLE;
  localparam int TXC_W      = $clog2(STOP_TICKS);
  localparam int BIT_W      = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
  localparam logic PAR_ODD  = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------- oversampling tick ----------------
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [1:0]       rx_sync_q;
  logic             rx_line;

  always_comb begin
    tick       = (tick_cnt_q == DIV_W'(DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      rx_sync_q  <= 2'b11;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rx_sync_q  <= {rx_sync_q[0], rx_in};
    end
  end

  assign rx_line = rx_sync_q[1];

  // ---------------- receiver ----------------
  state_t               rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_mid, rx_done;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ovr_q, rx_ovr_d;

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
    end
  end

  // The start bit is sampled half a bit after detection; every later bit a full bit apart.
  always_comb begin
    if (rx_state_q == ST_START) rx_mid = tick && (rx_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
    else                        rx_mid = tick && (rx_cnt_q == OS_W'(OVERSAMPLE - 1));
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    if (rx_state_q == ST_IDLE) begin
      if (tick && !rx_line) begin
        rx_state_d = ST_START;
        rx_cnt_d   = '0;
      end
    end else if (tick) begin
      rx_cnt_d = rx_mid ? '0 : rx_cnt_q + 1'b1;
      if (rx_mid) begin
        case (rx_state_q)
          ST_START: begin
            rx_state_d = rx_line ? ST_IDLE : ST_DATA;
            rx_bit_d   = '0;
          end
          ST_DATA: begin
            rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_d = ST_PARITY;
`else
              rx_state_d = ST_STOP;
`endif
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            rx_par_bad_d = rx_line ^ (^rx_shift_q) ^ PAR_ODD;
            rx_state_d   = ST_STOP;
          end
`endif
          ST_STOP: rx_state_d = ST_IDLE;
          default: rx_state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Completion outranks a same-cycle acknowledge, which then only suppresses the overrun.
  always_comb begin
    rx_done    = (rx_state_q == ST_STOP) && rx_mid;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ferr_d  = rx_ferr_q;
    rx_perr_d  = rx_perr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_ack) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    if (rx_done) begin
      rx_data_d  = rx_shift_q;
      rx_ferr_d  = !rx_line;
      rx_perr_d  = rx_par_bad_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) rx_ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;
  assign rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  // ---------------- transmitter ----------------
  state_t               tx_state_q, tx_state_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_last;

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_data_q  <= '0;
      tx_out_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_out_q   <= tx_out_d;
    end
  end

  // A bit starts on the first tick seen in its state and the state advances on its last tick.
  always_comb begin
    if (tx_state_q == ST_STOP) tx_last = (tx_cnt_q == TXC_W'(STOP_TICKS - 1));
    else                       tx_last = (tx_cnt_q == TXC_W'(OVERSAMPLE - 1));
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    if (tx_state_q == ST_IDLE) begin
      if (tx_start) begin
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_data_d  = tx_data;
      end
    end else if (tick) begin
      tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
      if (tx_last) begin
        case (tx_state_q)
          ST_START: tx_state_d = ST_DATA;
          ST_DATA: begin
            if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_d = ST_PARITY;
`else
              tx_state_d = ST_STOP;
`endif
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: tx_state_d = ST_STOP;
`endif
          default: tx_state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    tx_out_d = tx_out_q;
    if (tick) begin
      case (tx_state_q)
        ST_START: tx_out_d = 1'b0;
        ST_DATA:  tx_out_d = tx_data_q[tx_bit_q];
`ifdef UART_PARITY_EN
        ST_PARITY: tx_out_d = (^tx_data_q) ^ PAR_ODD;
`endif
        default:  tx_out_d = 1'b1;
      endcase
    end
  end

  assign tx_busy = (tx_state_q != ST_IDLE);
  assign tx_out  = tx_out_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core at default parameters (DIV 27, 432-cycle bits).
`timescale 1ns/1ps
module tb_uart_core;
  localparam int BIT = 432;
  localparam int DIV = 27;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       tx_start = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_out, tx_busy, rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
  logic [7:0] rx_data;
`ifdef UART_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  always #10 clk = ~clk;

  uart_core dut (
    .clk_50mhz    (clk),
    .reset        (rst_n),
    .rx_in        (rx_in),
    .tx_out       (tx_out),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-18s observed 0x%0h expected 0x%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame LSB first; a low stop bit is released just after its middle.
  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx_in = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      cycles(BIT);
    end
`ifdef UART_PARITY_EN
    rx_in = (^d) ^ par_flip;
    cycles(BIT);
`endif
    rx_in = stop_v;
    if (stop_v) begin
      cycles(BIT);
    end else begin
      cycles(280);
      rx_in = 1'b1;
      cycles(BIT - 280 + BIT);
    end
    rx_in = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    cycles(1);
    rx_ack = 1'b0;
  endtask

  // Starts a transmission and returns the cycles until tx_out falls.
  task automatic start_tx(input logic [7:0] d, output int lat);
    tx_data  = d;
    tx_start = 1'b1;
    cycles(1);
    tx_start = 1'b0;
    lat = 1;
    while (tx_out === 1'b1 && lat < 100) begin
      cycles(1);
      lat++;
    end
  endtask

  initial begin
    int         lat;
    int         n;
    logic [9:0] exp55;
    exp55 = 10'b10_1010_1010;

    cycles(5);
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_frame_err", rx_frame_err, 1'b0);
    check("rst_parity_err", rx_parity_err, 1'b0);
    check("rst_overrun", rx_overrun, 1'b0);
    rst_n = 1'b1;
    cycles(5);

    // Transmit 0x55
    start_tx(8'h55, lat);
    check("tx_busy_rise", tx_busy, 1'b1);
    check("tx_fall_seen", tx_out, 1'b0);
    check("tx_fall_latency", lat <= DIV + 1, 1'b1);
    cycles(BIT / 2);
    for (int b = 0; b < 10; b++) begin
      check($sformatf("tx55_bit%0d", b), tx_out, exp55[b]);
      if (b < 9) cycles(BIT);
    end
    check("tx_busy_in_stop", tx_busy, 1'b1);
    n = 0;
    while (tx_busy === 1'b1 && n < 400) begin
      cycles(1);
      n++;
    end
    check("tx_busy_fall", tx_busy, 1'b0);
    check("tx_busy_length", (BIT / 2 + 9 * BIT + n) inside {[4280:4325]}, 1'b1);

    // Receive 0xA3
    send_frame(8'hA3, 1'b1);
    check("rxA3_valid", rx_valid, 1'b1);
    check("rxA3_data", rx_data, 8'hA3);
    check("rxA3_frame_err", rx_frame_err, 1'b0);
    check("rxA3_overrun", rx_overrun, 1'b0);
    ack_pulse();
    check("rxA3_ack_clear", rx_valid, 1'b0);

    // False start then 0x0F
    rx_in = 1'b0;
    cycles(100);
    rx_in = 1'b1;
    cycles(BIT);
    check("false_start_valid", rx_valid, 1'b0);
    send_frame(8'h0F, 1'b1);
    check("rx0F_valid", rx_valid, 1'b1);
    check("rx0F_data", rx_data, 8'h0F);
    ack_pulse();

    // Framing error then a clean frame
    send_frame(8'h3C, 1'b0);
    check("rx3C_valid", rx_valid, 1'b1);
    check("rx3C_data", rx_data, 8'h3C);
    check("rx3C_frame_err", rx_frame_err, 1'b1);
    ack_pulse();
    send_frame(8'h81, 1'b1);
    check("rx81_data", rx_data, 8'h81);
    check("rx81_frame_err", rx_frame_err, 1'b0);
    ack_pulse();

    // Overrun
    send_frame(8'h11, 1'b1);
    check("rx11_overrun", rx_overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    check("rx22_data", rx_data, 8'h22);
    check("rx22_valid", rx_valid, 1'b1);
    check("rx22_overrun", rx_overrun, 1'b1);
    ack_pulse();
    check("ovr_ack_valid", rx_valid, 1'b0);
    check("ovr_ack_overrun", rx_overrun, 1'b0);

`ifdef UART_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    check("rx07_data", rx_data, 8'h07);
    check("rx07_parity_err", rx_parity_err, 1'b1);
    ack_pulse();
    start_tx(8'h07, lat);
    cycles(BIT / 2 + 9 * BIT);
    check("tx07_parity_bit", tx_out, 1'b1);
    n = 0;
    while (tx_busy === 1'b1 && n < 2 * BIT) begin
      cycles(1);
      n++;
    end
    check("tx07_done", tx_busy, 1'b0);
`endif

    // Reset in the middle of a transmission
    start_tx(8'h00, lat);
    cycles(1000);
    check("midtx_tx_out", tx_out, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("midtx_rst_tx_out", tx_out, 1'b1);
    check("midtx_rst_busy", tx_busy, 1'b0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
